// File: rtl/cdc_pkg.sv
// Shared definitions for the sync-to-async QDI transmit path: FSM state codes and 1of4 encoding.
package cdc_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_DATA    = 2'd1;
  localparam state_t ST_NEUTRAL = 2'd2;

  // Two-bit value to one-hot rail set; value v raises rail v.
  function automatic logic [3:0] enc_1of4(input logic [1:0] v);
    logic [3:0] r;
    case (v)
      2'd0:    r = 4'b0001;
      2'd1:    r = 4'b0010;
      2'd2:    r = 4'b0100;
      2'd3:    r = 4'b1000;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cdc_sync_ff.sv
// Multi-flop synchronizer for one asynchronous enable bit.
module cdc_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the raw input through the synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/cdc_s2a_qdi_tx.sv
// Clocked valid/ready words in, 4-phase 1of4 QDI tokens out, decoupled by a small word FIFO.
module cdc_s2a_qdi_tx
  import cdc_pkg::*;
#(
  parameter int DW          = 64,
  parameter int DEPTH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DW-1:0]     Din,
  input  logic              Si,
  output logic              So,
  output logic [2*DW-1:0]   Tx,
  input  logic [DW/2-1:0]   Txe,
  output logic              Empty
);

  localparam int DIGITS = DW / 2;
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DIGITS-1:0] txe_s;
  logic              all_hi_s;
  logic              all_lo_s;
  logic              push_s;
  logic              pop_s;
  logic [DW-1:0]     head_s;
  logic [2*DW-1:0]   tx_enc_s;
  logic [2*DW-1:0]   tx_nxt_s;
  state_t            state_nxt_s;
  logic [CW-1:0]     count_nxt_s;

  logic [DW-1:0]     mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  state_t            state_r;
  logic [2*DW-1:0]   tx_r;
  logic              so_r;
  logic              empty_r;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_sync
      cdc_sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (CLK),
        .rst (RESET),
        .d   (Txe[g]),
        .q   (txe_s[g])
      );
    end
  endgenerate

  assign all_hi_s = &txe_s;
  assign all_lo_s = ~|txe_s;
  assign push_s   = Si && so_r;
  assign head_s   = mem_r[rd_ptr_r];

  // Encode the FIFO head digit by digit so it can be loaded onto the rails in one edge.
  always_comb begin
    tx_enc_s = '0;
    for (int k = 0; k < DIGITS; k++) begin
      tx_enc_s[4*k +: 4] = enc_1of4(head_s[2*k +: 2]);
    end
  end

  // Handshake FSM; mixed enable patterns leave state and rails untouched.
  always_comb begin
    state_nxt_s = state_r;
    tx_nxt_s    = tx_r;
    pop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if ((count_r != '0) && all_hi_s) begin
          pop_s       = 1'b1;
          tx_nxt_s    = tx_enc_s;
          state_nxt_s = ST_DATA;
        end else begin
          tx_nxt_s    = '0;
        end
      end
      ST_DATA: begin
        if (all_lo_s) begin
          tx_nxt_s    = '0;
          state_nxt_s = ST_NEUTRAL;
        end else begin
          tx_nxt_s    = tx_r;
        end
      end
      ST_NEUTRAL: begin
        tx_nxt_s = '0;
        if (all_hi_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_NEUTRAL;
        end
      end
      default: begin
        tx_nxt_s    = '0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign count_nxt_s = count_r + CW'(push_s) - CW'(pop_s);

  // Control state; So and Empty are registered from next-state values so they stay glitch-free.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r  <= ST_IDLE;
      tx_r     <= '0;
      count_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      so_r     <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      tx_r    <= tx_nxt_s;
      count_r <= count_nxt_s;
      so_r    <= (count_nxt_s != CW'(DEPTH));
      empty_r <= (count_nxt_s == '0) && (state_nxt_s == ST_IDLE);
      if (push_s) begin
        wr_ptr_r <= (wr_ptr_r == PW'(DEPTH - 1)) ? '0 : wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PW'(DEPTH - 1)) ? '0 : rd_ptr_r + PW'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= Din;
    end
  end

  assign So    = so_r;
  assign Tx    = tx_r;
  assign Empty = empty_r;

endmodule

// File: tb/tb_cdc_s2a_qdi_tx.sv
// Directed and randomized checks of the sync-to-async QDI transmitter with a behavioural receiver.
module tb_cdc_s2a_qdi_tx;

  localparam int DW  = 64;
  localparam int DIG = DW / 2;

  logic            CLK = 1'b0;
  logic            RESET;
  logic [DW-1:0]   Din;
  logic            Si;
  logic            So;
  logic [2*DW-1:0] Tx;
  logic [DIG-1:0]  Txe;
  logic            Empty;

  int errors = 0;
  int checks = 0;
  int tx_count = 0;
  int rx_count = 0;

  always #5 CLK = ~CLK;

  cdc_s2a_qdi_tx #(.DW(DW), .DEPTH(2), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RESET(RESET), .Din(Din), .Si(Si), .So(So),
    .Tx(Tx), .Txe(Txe), .Empty(Empty)
  );

  function automatic logic [DW-1:0] dec_word(input logic [2*DW-1:0] t);
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < DIG; k++) begin
      case (t[4*k +: 4])
        4'b0010: w[2*k +: 2] = 2'd1;
        4'b0100: w[2*k +: 2] = 2'd2;
        4'b1000: w[2*k +: 2] = 2'd3;
        default: w[2*k +: 2] = 2'd0;
      endcase
    end
    return w;
  endfunction

  function automatic bit onehot_ok(input logic [2*DW-1:0] t);
    bit ok;
    ok = 1'b1;
    for (int k = 0; k < DIG; k++) begin
      if ($countones(t[4*k +: 4]) != 1) ok = 1'b0;
    end
    return ok;
  endfunction

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic push_word(input logic [DW-1:0] w, output bit ok);
    int n;
    ok = 1'b0; n = 0;
    Si = 1'b1; Din = w;
    while (!So && n < 300) begin @(negedge CLK); n++; end
    if (So) begin
      @(negedge CLK);
      ok = 1'b1;
      tx_count++;
    end
    Si = 1'b0;
  endtask

  // Receiver: raise enables, capture a token, acknowledge, wait for neutral. Leaves Txe low.
  task automatic rx_token(output logic [DW-1:0] w, output bit got, output bit oh);
    int n;
    got = 1'b0; oh = 1'b0; w = '0; n = 0;
    Txe = '1;
    while (Tx == '0 && n < 300) begin @(negedge CLK); n++; end
    if (Tx != '0) begin
      oh = onehot_ok(Tx);
      w  = dec_word(Tx);
      Txe = '0;
      n = 0;
      while (Tx != '0 && n < 300) begin @(negedge CLK); n++; end
      if (Tx == '0) begin
        got = 1'b1;
        rx_count++;
      end
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1; Si = 1'b0; Din = '0; Txe = '1;
    repeat (5) @(negedge CLK);
    checks++; if (Tx !== '0) begin errors++; $display("FAIL reset_tx: got %h want 0", Tx); end
    checks++; if (So !== 1'b0) begin errors++; $display("FAIL reset_so: got %b want 0", So); end
    checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", Empty); end
    RESET = 1'b0;
    #1;
    checks++; if (So !== 1'b0) begin errors++; $display("FAIL release_so_before_edge: got %b want 0", So); end
    @(negedge CLK);
    checks++; if (So !== 1'b1) begin errors++; $display("FAIL release_so: got %b want 1", So); end
  endtask

  task automatic test_single_token;
    logic [DW-1:0] w;
    w = 64'h0123_4567_89AB_CDEF;
    repeat (3) @(negedge CLK);
    Si = 1'b1; Din = w;
    checks++; if (So !== 1'b1) begin errors++; $display("FAIL single_so: got %b want 1", So); end
    @(negedge CLK);
    Si = 1'b0;
    checks++; if (Tx !== '0) begin errors++; $display("FAIL single_early: got %h want 0", Tx); end
    @(negedge CLK);
    checks++; if (Tx[3:0] !== 4'b1000) begin errors++; $display("FAIL single_d0: got %b want 1000", Tx[3:0]); end
    checks++; if (Tx[7:4] !== 4'b1000) begin errors++; $display("FAIL single_d1: got %b want 1000", Tx[7:4]); end
    checks++; if (Tx[127:124] !== 4'b0001) begin errors++; $display("FAIL single_d31: got %b want 0001", Tx[127:124]); end
    checks++; if (dec_word(Tx) !== w || !onehot_ok(Tx)) begin errors++; $display("FAIL single_word: got %h want %h", dec_word(Tx), w); end
    checks++; if (Empty !== 1'b0) begin errors++; $display("FAIL single_empty_data: got %b want 0", Empty); end
    Txe = '0;
    repeat (2) @(negedge CLK);
    checks++; if (dec_word(Tx) !== w || Tx == '0) begin errors++; $display("FAIL single_hold: got %h want %h", dec_word(Tx), w); end
    @(negedge CLK);
    checks++; if (Tx !== '0) begin errors++; $display("FAIL single_neutral: got %h want 0", Tx); end
    Txe = '1;
    repeat (2) @(negedge CLK);
    checks++; if (Empty !== 1'b0) begin errors++; $display("FAIL single_empty_early: got %b want 0", Empty); end
    @(negedge CLK);
    checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL single_empty_idle: got %b want 1", Empty); end
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] wv [3];
    logic [DW-1:0] rw [3];
    bit            rg [3];
    bit            ro [3];
    bit            ok0, ok1, ok2;
    int            n;
    wv[0] = 64'h1111_2222_3333_4444;
    wv[1] = 64'hA5A5_5A5A_F0F0_0F0F;
    wv[2] = 64'hDEAD_BEEF_CAFE_F00D;
    Txe = '0;
    repeat (4) @(negedge CLK);
    push_word(wv[0], ok0);
    push_word(wv[1], ok1);
    checks++; if (!(ok0 && ok1)) begin errors++; $display("FAIL bp_push01: got %b%b want 11", ok0, ok1); end
    checks++; if (So !== 1'b0) begin errors++; $display("FAIL bp_full_so: got %b want 0", So); end
    Si = 1'b1; Din = wv[2];
    repeat (4) @(negedge CLK);
    checks++; if (So !== 1'b0 || Tx !== '0) begin errors++; $display("FAIL bp_held: got so=%b tx=%h want so=0 tx=0", So, Tx); end
    fork
      push_word(wv[2], ok2);
      for (int i = 0; i < 3; i++) rx_token(rw[i], rg[i], ro[i]);
    join
    checks++; if (!ok2) begin errors++; $display("FAIL bp_push2: got %b want 1", ok2); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (!rg[i] || !ro[i] || rw[i] !== wv[i]) begin
        errors++; $display("FAIL bp_token%0d: got %h want %h (got=%b onehot=%b)", i, rw[i], wv[i], rg[i], ro[i]);
      end
    end
    Txe = '1; n = 0;
    while (!Empty && n < 50) begin @(negedge CLK); n++; end
    checks++; if (Empty !== 1'b1 || Tx !== '0) begin errors++; $display("FAIL bp_drain: got empty=%b tx=%h want 1/0", Empty, Tx); end
  endtask

  task automatic test_mixed_enables;
    logic [DW-1:0]   w;
    logic [2*DW-1:0] cap;
    bit              ok;
    int              n;
    w = 64'hFEDC_BA98_7654_3210;
    Txe = '1;
    push_word(w, ok);
    n = 0;
    while (Tx == '0 && n < 50) begin @(negedge CLK); n++; end
    cap = Tx;
    checks++; if (!ok || dec_word(cap) !== w) begin errors++; $display("FAIL mixed_token: got %h want %h", dec_word(cap), w); end
    Txe = {16'hFFFF, 16'h0000};
    repeat (6) @(negedge CLK);
    checks++; if (Tx !== cap || Empty !== 1'b0) begin errors++; $display("FAIL mixed_hold: got %h want %h", Tx, cap); end
    Txe = '0; n = 0;
    while (Tx != '0 && n < 50) begin @(negedge CLK); n++; end
    checks++; if (Tx !== '0) begin errors++; $display("FAIL mixed_neutral: got %h want 0", Tx); end
    Txe = '1; n = 0;
    while (!Empty && n < 50) begin @(negedge CLK); n++; end
    checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL mixed_idle: got %b want 1", Empty); end
  endtask

  task automatic test_reset_mid_token;
    bit ok;
    int n;
    Txe = '1;
    push_word(64'h0F0F_0F0F_1234_5678, ok);
    n = 0;
    while (Tx == '0 && n < 50) begin @(negedge CLK); n++; end
    push_word(64'h7777_8888_9999_AAAA, ok);
    checks++; if (Tx == '0 || !ok) begin errors++; $display("FAIL rmid_setup: got tx=%h ok=%b want nonzero/1", Tx, ok); end
    #2 RESET = 1'b1;
    #1;
    checks++; if (Tx !== '0 || So !== 1'b0 || Empty !== 1'b1) begin
      errors++; $display("FAIL rmid_async: got tx=%h so=%b empty=%b want 0/0/1", Tx, So, Empty);
    end
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    repeat (12) @(negedge CLK);
    checks++; if (Tx !== '0 || Empty !== 1'b1) begin errors++; $display("FAIL rmid_fifo_cleared: got tx=%h empty=%b want 0/1", Tx, Empty); end
  endtask

  task automatic test_soak;
    logic [DW-1:0] exp_q [$];
    int            n;
    tx_count = 0; rx_count = 0;
    Txe = '1;
    fork
      begin
        logic [DW-1:0] w;
        bit            ok;
        for (int i = 0; i < 16; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge CLK);
          w = {$urandom, $urandom};
          exp_q.push_back(w);
          push_word(w, ok);
          checks++; if (!ok) begin errors++; $display("FAIL soak_push%0d: got 0 want 1", i); end
        end
      end
      begin
        logic [DW-1:0] rw, ew;
        bit            rg, ro;
        for (int i = 0; i < 16; i++) begin
          repeat ($urandom_range(0, 4)) @(negedge CLK);
          rx_token(rw, rg, ro);
          ew = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
          checks++;
          if (!rg || !ro || rw !== ew) begin
            errors++; $display("FAIL soak_token%0d: got %h want %h (got=%b onehot=%b)", i, rw, ew, rg, ro);
          end
        end
      end
    join
    Txe = '1; n = 0;
    while (!Empty && n < 50) begin @(negedge CLK); n++; end
    checks++; if (tx_count != rx_count || rx_count != 16) begin errors++; $display("FAIL soak_counts: got tx=%0d rx=%0d want 16/16", tx_count, rx_count); end
    checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL soak_empty: got %b want 1", Empty); end
  endtask

  initial begin
    RESET = 1'b1; Si = 1'b0; Din = '0; Txe = '1;
    @(negedge CLK);
    test_reset;
    test_single_token;
    test_backpressure;
    test_mixed_enables;
    test_reset_mid_token;
    test_soak;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
